// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial receive path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_pkg;

    // Line level while nothing is being transmitted
    localparam logic IDLE_LEVEL = 1'b1;

    // Receive sequencer states
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Bits needed to hold values 0..value-1
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Phase counter for one serial bit: 0..CLKS_PER_BIT-1 with half-bit and full-bit ticks.
// Latency: ticks are combinational decodes of the counter; reload takes effect on the next edge.
// Backpressure: none, free-running while reload is low.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic half_tick,
    output logic full_tick
);
    import serial_pkg::*;

    localparam int PW = clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0] HALF_LAST = PW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PW-1:0] FULL_LAST = PW'(CLKS_PER_BIT - 1);

    logic [PW-1:0] phase;

    // Count through one bit period; a reload or the terminal count restarts at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (reload || (phase == FULL_LAST)) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign half_tick = (phase == HALF_LAST);
    assign full_tick = (phase == FULL_LAST);

endmodule

// File: rtl/serial_rx_ctrl.sv
// Serial receive sequencer: start detect, mid-bit sampling, LSB-first shift, one-entry output buffer.
// Latency: out_valid rises on the stop-bit sample edge, (DATA_BITS+1.5)*CLKS_PER_BIT+3 clk after the start edge.
// Backpressure: a full buffer without out_ready drops the new byte and pulses overrun.
// Optional even-parity bit between data and stop: define SERIAL_RX_PARITY_EN.
module serial_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);
    import serial_pkg::*;

    localparam int BW = clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx;
    rx_state_t            state;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 half_tick;
    logic                 full_tick;
    logic                 reload;
    logic                 stop_sample;
    logic                 deliver;
    logic                 par_bad;

    // Two-flop synchronizer for the asynchronous line, resting at the idle level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= IDLE_LEVEL;
            rx      <= IDLE_LEVEL;
        end else begin
            rx_meta <= rxd;
            rx      <= rx_meta;
        end
    end

    // The timer is held at zero while idle or waiting out a break, and restarted when
    // the start bit is confirmed; DATA/PARITY/STOP entries coincide with the natural
    // wrap at the full-bit tick, so every state starts its bit period from phase zero.
    assign reload = (state == IDLE) || (state == BREAK) || ((state == START) && half_tick);

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .reload   (reload),
        .half_tick(half_tick),
        .full_tick(full_tick)
    );

    assign busy        = (state != IDLE);
    assign stop_sample = (state == STOP) && full_tick;
    assign deliver     = stop_sample && (rx == IDLE_LEVEL) && !par_bad;

    // Frame sequencer: start qualification, data shifting, stop check, break wait
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx != IDLE_LEVEL) begin
                        state <= START;
                    end
                end
                START: begin
                    if (half_tick) begin
                        if (rx != IDLE_LEVEL) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            // Line went back high before mid-start: treat as a glitch
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (full_tick) begin
                        // Line order is LSB first, so each new bit enters at the top
                        shreg   <= {rx, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
                PARITY: begin
                    if (full_tick) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (full_tick) begin
                        if (rx == IDLE_LEVEL) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // A line held low must return high before a new start is accepted
                    if (rx == IDLE_LEVEL) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    // Even parity over data plus parity bit; verdict is held until the stop-bit sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= stop_sample && par_bad;
            if ((state == PARITY) && full_tick) begin
                par_bad <= ((^shreg) != rx);
            end
        end
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    // One-entry output buffer: load on a good frame if empty or drained this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver && (!out_valid || out_ready)) begin
                out_data  <= shreg;
                out_valid <= 1'b1;
            end else begin
                if (deliver) begin
                    overrun <= 1'b1;
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Bench for serial_rx_ctrl: directed frames plus randomized traffic against a frame-level model.
// Latency: n/a.
// Backpressure: out_ready is driven directly or randomized per cycle.
module tb_serial_rx_ctrl;
    localparam int CPB = 8;
    localparam int DB  = 8;
`ifdef SERIAL_RX_PARITY_EN
    localparam int PB  = 1;
    localparam int LAT = 87;
`else
    localparam int PB  = 0;
    localparam int LAT = 79;
`endif
    localparam int NBITS = 1 + DB + PB + 1;
    localparam int NEVER = 32'h3fff_ffff;

    typedef struct {
        int         cyc;
        bit         fe;
        bit         pe;
        logic [7:0] data;
    } ev_t;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          rxd       = 1'b1;
    logic          out_ready = 1'b0;
    logic [DB-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic          frame_err;
    logic          overrun;
    logic          parity_err;

    serial_rx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rdy_at_edge = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rdy_at_edge <= out_ready;

    int   checks = 0;
    int   errors = 0;
    ev_t  evq[$];
    logic exp_v = 1'b0;
    logic [7:0] exp_d = 8'h00;
    int   busy_lo = 0;
    int   busy_hi = 0;
    int   last_n = 0;
    bit   rand_rdy = 1'b0;

    int   nv, nfe, nov, npe, first_v;
    logic [7:0] last_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic clr_tally();
        nv = 0; nfe = 0; nov = 0; npe = 0; first_v = -1; last_d = 8'h00;
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: buffer occupancy from frame outcomes and the handshake rules
    ev_t  ev;
    bit   have_ev, good, exp_fe, exp_ov, exp_pe;
    always @(negedge clk) begin
        exp_fe = 1'b0; exp_ov = 1'b0; exp_pe = 1'b0;
        if (rst) begin
            exp_v = 1'b0;
            chk("reset_data", out_data, 0);
        end else begin
            have_ev = (evq.size() > 0) && (evq[0].cyc == cyc);
            good    = 1'b0;
            if (have_ev) begin
                ev     = evq.pop_front();
                good   = !ev.fe && !ev.pe;
                exp_fe = ev.fe;
                exp_pe = ev.pe;
            end
            if (good && (!exp_v || rdy_at_edge)) begin
                exp_v = 1'b1;
                exp_d = ev.data;
            end else begin
                exp_ov = good;
                if (exp_v && rdy_at_edge) exp_v = 1'b0;
            end
            if (exp_v) chk("out_data", out_data, exp_d);
        end
        chk("out_valid", out_valid, exp_v);
        chk("frame_err", frame_err, exp_fe);
        chk("overrun", overrun, exp_ov);
        chk("parity_err", parity_err, exp_pe);
        chk("busy", busy, (cyc >= busy_lo) && (cyc < busy_hi));
        if (out_valid) begin
            nv++;
            if (first_v < 0) first_v = cyc;
            last_d = out_data;
        end
        if (frame_err) nfe++;
        if (overrun) nov++;
        if (parity_err) npe++;
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send_frame(input logic [7:0] d, input bit bad_stop, input bit bad_par,
                              input int low_hold);
        logic [NBITS-1:0] line;
        ev_t e;
        line[0] = 1'b0;
        for (int i = 0; i < DB; i++) line[1 + i] = d[i];
`ifdef SERIAL_RX_PARITY_EN
        line[1 + DB] = (^d) ^ bad_par;
`endif
        line[NBITS-1] = !bad_stop;
        step(1);
        last_n  = cyc;
        busy_lo = cyc + 3;
        e.cyc   = cyc + 3 + CPB / 2 + (NBITS - 1) * CPB;
        e.fe    = bad_stop;
        e.pe    = bad_par;
        e.data  = d;
        busy_hi = bad_stop ? NEVER : e.cyc;
        evq.push_back(e);
        for (int j = 0; j < NBITS; j++) begin
            rxd = line[j];
            step(CPB);
        end
        if (bad_stop) begin
            step(low_hold);
            chk("break_busy", busy, 1);
            busy_hi = cyc + 3;
        end
        rxd = 1'b1;
    endtask

    task automatic send_glitch(input int len);
        step(1);
        busy_lo = cyc + 3;
        busy_hi = cyc + 3 + CPB / 2;
        rxd = 1'b0;
        step(len);
        rxd = 1'b1;
    endtask

    int n2, e2, r;
    initial begin
        clr_tally();
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", out_data, 0);
        step(3);
        rst = 1'b0;
        step(4);

        // 0xA5 with the consumer always ready
        clr_tally();
        out_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0, 0);
        step(4);
        chk("a5_valid_cycles", nv, 1);
        chk("a5_data", last_d, 8'hA5);
        chk("a5_latency", first_v - last_n, LAT);
        chk("a5_no_ferr", nfe, 0);
        chk("a5_no_ovr", nov, 0);

        // Short low glitch must not start a frame
        clr_tally();
        send_glitch(3);
        step(CPB);
        chk("glitch_valid", nv, 0);
        chk("glitch_busy", busy, 0);
        chk("glitch_ferr", nfe, 0);

        // Bad stop bit then line held low
        clr_tally();
        send_frame(8'h3C, 1'b1, 1'b0, 40);
        step(8);
        chk("brk_ferr_count", nfe, 1);
        chk("brk_valid", nv, 0);
        chk("brk_busy_after", busy, 0);

        // Overrun: second byte dropped while buffer held
        clr_tally();
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 0);
        step(4);
        send_frame(8'h22, 1'b0, 1'b0, 0);
        step(4);
        chk("ovr_data", out_data, 8'h11);
        chk("ovr_valid", out_valid, 1);
        chk("ovr_count", nov, 1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("ovr_drained", out_valid, 0);
        step(2);

        // Accept and load on the same edge
        clr_tally();
        send_frame(8'h11, 1'b0, 1'b0, 0);
        step(4);
        fork
            send_frame(8'h22, 1'b0, 1'b0, 0);
            begin
                step(1);
                n2 = cyc;
                e2 = n2 + 3 + CPB / 2 + (NBITS - 1) * CPB;
                step(e2 - 1 - n2);
                out_ready = 1'b1;
                step(1);
                out_ready = 1'b0;
            end
        join
        step(2);
        chk("swap_valid", out_valid, 1);
        chk("swap_data", out_data, 8'h22);
        chk("swap_no_ovr", nov, 0);
        out_ready = 1'b1;
        step(2);

        // Reset during the 4th data bit of 0xFF, with a byte waiting in the buffer
        out_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b0, 0);
        step(4);
        step(1);
        busy_lo = cyc + 3;
        busy_hi = NEVER;
        rxd = 1'b0;
        step(CPB);
        rxd = 1'b1;
        step(3 * CPB + CPB / 2);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        busy_hi = cyc;
        evq.delete();
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", out_data, 0);
        step(2);
        rst = 1'b0;
        step(4);
        clr_tally();
        out_ready = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 0);
        step(4);
        chk("post_rst_count", nv, 1);
        chk("post_rst_data", last_d, 8'h5A);

        // Randomized traffic with random backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send_glitch($urandom_range(1, CPB / 2));
            end else begin
`ifdef SERIAL_RX_PARITY_EN
                send_frame(8'($urandom), r == 1, r == 2, $urandom_range(0, 20));
`else
                send_frame(8'($urandom), r == 1, 1'b0, $urandom_range(0, 20));
`endif
            end
            step($urandom_range(4, 12));
        end
        rand_rdy = 1'b0;
        step(1);
        out_ready = 1'b1;
        step(4);
        chk("events_left", evq.size(), 0);
        chk("final_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_rx_ctrl.md
Name: serial_rx_ctrl

Overview:
Receive-side sequencer for the serial link. It detects the start bit on the asynchronous rxd line, times the mid-bit sampling points, and steps the received-bit count through start, data and stop. It shifts in the data bits (LSB first) and delivers each completed byte through a one-entry valid/ready output buffer to the downstream logic.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and >= 4.
DATA_BITS, 8, data bits per frame; range 5..8.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
rxd  input  1  serial line, asynchronous, idle high
out_data  output  DATA_BITS  received byte, stable while out_valid=1
out_valid  output  1  out_data holds an unconsumed byte
out_ready  input  1  consumer accepts out_data when out_valid&out_ready
busy  output  1  high in every state except IDLE
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed byte dropped, buffer still full
parity_err  output  1  one-cycle pulse: parity mismatch (0 unless feature compiled in)

Behaviour:
- Reset (async, rst=1): state=IDLE, sync flops=1, out_valid=0, out_data=0, busy=0, all pulses 0, counters 0.
- rxd passes through a 2-flop synchronizer (reset value 1). "rx" means the synchronized value. Sampling happens on the 3rd clk after a line change.
- Phase counter: counts 0..CLKS_PER_BIT-1 and emits a tick on terminal count. It is reloaded on every state entry.
- IDLE: rx==0 -> START, phase counter cleared.
- START: at CLKS_PER_BIT/2 cycles, sample rx.
  - rx==0: go to DATA, bit count=0.
  - rx==1: glitch; return to IDLE, no pulses.
- DATA: on each full-bit tick, shift rx into the MSB of the shift register (LSB-first line order). Increment bit count. After DATA_BITS samples go to STOP (or PARITY, see feature).
- STOP: on the tick, sample rx.
  - rx==1: frame complete; go to IDLE the next cycle.
  - rx==0: pulse frame_err, discard the byte, go to BREAK.
- BREAK: wait for rx==1, then IDLE. This prevents a held-low line from retriggering.
- Delivery on frame complete:
  - if out_valid==0, or out_ready==1 in the same cycle: load out_data, set out_valid=1.
  - else pulse overrun, keep the old out_data, drop the new byte.
- Handshake: out_valid clears on the cycle after out_valid&out_ready unless a load occurs in that same cycle. Simultaneous accept and load leaves out_valid=1 with the new data.
- Latency: out_valid rises 1 clk after the stop-bit sample, i.e. about (DATA_BITS+1.5)*CLKS_PER_BIT+3 clk after the rxd falling edge.
- Bit count width is clog2(DATA_BITS+1). Phase counter width is clog2(CLKS_PER_BIT). No wrap occurs beyond the terminal values.
- rst asserted mid-frame aborts immediately: the partial byte is lost and out_valid returns to 0.

Optional Feature:
Macro SERIAL_RX_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP and samples one even-parity bit on its tick. A mismatch pulses parity_err at the stop-bit sample and suppresses delivery. Any stop-bit error is still reported via frame_err.
- Undefined: no PARITY state, and parity_err is tied to 0.

Decomposition:
- Shared package serial_pkg:
  - state encoding enum (IDLE, START, DATA, PARITY, STOP, BREAK)
  - localparam IDLE_LEVEL=1
  - function clog2
- One natural sub-module: serial_bit_timer. It holds the phase counter with half-bit/full-bit tick outputs and reload input, and is instantiated once.

Test Plan:
- CLKS_PER_BIT=8. Send 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) with out_ready=1 -> out_valid one cycle, out_data=0xA5, no error pulses.
- rxd low for 3 clk, then high -> START aborts to IDLE, busy falls, no out_valid, no pulses.
- Send 0x3C with stop bit driven 0, then rxd held low 40 clk -> frame_err pulse once, no out_valid, busy stays high until rxd returns high.
- out_ready=0. Send 0x11 then 0x22 -> out_data stays 0x11, one overrun pulse at the second stop sample. Raise out_ready -> 0x11 consumed, out_valid=0.
- out_ready=0, send 0x11; assert out_ready exactly on the cycle 0x22 completes -> no overrun, out_valid stays 1, out_data=0x22.
- Assert rst during the 4th data bit of 0xFF -> all outputs reset immediately. The next clean frame 0x5A is received correctly.
